nios_system_onchip_memory_arbiter: RTL and testbench

- Shares the single-port 1024x32 on-chip RAM between two Avalon-MM requesters: m0 (Nios data master) and m1 (DMA/peripheral master).
- Sits between both masters and the RAM's s1 port.
- Provides per-master waitrequest and readdatavalid.
- Uses round-robin arbitration with a bounded hold count, so a streaming master cannot starve the other.

---
 rtl/nios_mem_arb_pkg.sv | 19 +
 rtl/nios_mem_arb_rdpipe.sv | 31 +++
 rtl/nios_system_onchip_memory_arbiter.sv | 129 ++++++++++++
 tb/tb_nios_system_onchip_memory_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_mem_arb_pkg.sv
// Shared types and constants for the two-master on-chip RAM arbiter.
package nios_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } owner_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   // One slot of the read-return pipeline: which master a returning word belongs to.
   typedef struct packed {
      logic valid;
      logic id;
   } rd_entry_t;

endpackage

// File: rtl/nios_mem_arb_rdpipe.sv
// Fixed-depth {valid, id} shift register tracking reads in flight to the RAM.
module nios_mem_arb_rdpipe
   import nios_mem_arb_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic      clk,
   input  logic      reset_n,
   input  rd_entry_t push_entry,
   output rd_entry_t tail_entry
);

   rd_entry_t stage_reg [DEPTH];

   // Reset drops every in-flight read so it is never returned.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_reg[i] <= '0;
         end
      end else begin
         stage_reg[0] <= push_entry;
         for (int i = 1; i < DEPTH; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign tail_entry = stage_reg[DEPTH-1];

endmodule

// File: rtl/nios_system_onchip_memory_arbiter.sv
// Round-robin arbiter with bounded hold sharing one single-port RAM between two Avalon-MM masters.
module nios_system_onchip_memory_arbiter
   import nios_mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 32,
   parameter int BE_W         = 4,
   parameter int READ_LATENCY = 1,
   parameter int MAX_HOLD     = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

   owner_t            owner_reg;
   logic [3:0]        hold_cnt_reg;
   logic              rr_last_reg;
   logic [ADDR_W-1:0] addr_last_reg;
   logic [BE_W-1:0]   be_last_reg;
   logic [DATA_W-1:0] wdata_last_reg;

   logic      req0, req1, grant0, grant1, accept, sel_write, sel_read;
   owner_t    owner_next;
   rd_entry_t push_entry, tail_entry;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   // Owner keeps the RAM while under its hold budget or uncontested; otherwise round-robin.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (owner_reg == OWN0 && req0 && (!req1 || hold_cnt_reg < MAX_HOLD_C)) begin
         grant0 = 1'b1;
      end else if (owner_reg == OWN1 && req1 && (!req0 || hold_cnt_reg < MAX_HOLD_C)) begin
         grant1 = 1'b1;
      end else if (req0 && !req1) begin
         grant0 = 1'b1;
      end else if (req1 && !req0) begin
         grant1 = 1'b1;
      end else if (req0 && req1) begin
         grant0 = (rr_last_reg == M1);
         grant1 = (rr_last_reg == M0);
      end
   end

   assign accept     = grant0 | grant1;
   assign owner_next = grant1 ? OWN1 : OWN0;
   assign sel_write  = grant0 ? m0_write : m1_write;
   assign sel_read   = accept & ~sel_write;

   assign m0_waitrequest = req0 & ~grant0;
   assign m1_waitrequest = req1 & ~grant1;

   assign mem_clken      = 1'b1;
   assign mem_chipselect = accept & reset_n;
   assign mem_write      = mem_chipselect & sel_write;
   assign mem_address    = grant0 ? m0_address    : (grant1 ? m1_address    : addr_last_reg);
   assign mem_byteenable = grant0 ? m0_byteenable : (grant1 ? m1_byteenable : be_last_reg);
   assign mem_writedata  = grant0 ? m0_writedata  : (grant1 ? m1_writedata  : wdata_last_reg);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner_reg      <= IDLE;
         hold_cnt_reg   <= 4'd0;
         rr_last_reg    <= M1;
         addr_last_reg  <= '0;
         be_last_reg    <= '0;
         wdata_last_reg <= '0;
      end else if (accept) begin
         owner_reg      <= owner_next;
         rr_last_reg    <= grant1 ? M1 : M0;
         addr_last_reg  <= mem_address;
         be_last_reg    <= mem_byteenable;
         wdata_last_reg <= mem_writedata;
         if (owner_reg != owner_next) begin
            hold_cnt_reg <= 4'd1;
         end else if (hold_cnt_reg != 4'hF) begin
            hold_cnt_reg <= hold_cnt_reg + 4'd1;
         end
      end else begin
         owner_reg    <= IDLE;
         hold_cnt_reg <= 4'd0;
      end
   end

   assign push_entry.valid = sel_read;
   assign push_entry.id    = grant1 ? M1 : M0;

   nios_mem_arb_rdpipe #(
      .DEPTH (READ_LATENCY)
   ) u_rdpipe (
      .clk        (clk),
      .reset_n    (reset_n),
      .push_entry (push_entry),
      .tail_entry (tail_entry)
   );

   assign m0_readdatavalid = tail_entry.valid & (tail_entry.id == M0);
   assign m1_readdatavalid = tail_entry.valid & (tail_entry.id == M1);
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_nios_system_onchip_memory_arbiter.sv
// Directed bench for the two-master RAM arbiter, backed by a 1-cycle-latency RAM model.
module tb_nios_system_onchip_memory_arbiter;

   logic        clk;
   logic        reset_n;
   logic [9:0]  m0_address, m1_address;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [9:0]  mem_address;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] ram [1024];

   nios_system_onchip_memory_arbiter dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .m0_address       (m0_address),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_byteenable    (m0_byteenable),
      .m0_writedata     (m0_writedata),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_byteenable    (m1_byteenable),
      .m1_writedata     (m1_writedata),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .mem_address      (mem_address),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_byteenable   (mem_byteenable),
      .mem_writedata    (mem_writedata),
      .mem_clken        (mem_clken),
      .mem_readdata     (mem_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM with registered read data: valid the cycle after the read is issued.
   always @(posedge clk) begin
      if (mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end
         end else begin
            mem_readdata <= ram[mem_address];
         end
      end
   end

   task automatic idle_all();
      m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_all();
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic preload(input logic [9:0] addr, input logic [31:0] data);
      @(negedge clk);
      idle_all();
      m1_write = 1'b1; m1_address = addr; m1_byteenable = 4'hF; m1_writedata = data;
      @(negedge clk);
      idle_all();
   endtask

   task automatic test_reset();
      @(negedge clk);
      m0_read = 1'b1; m0_address = 10'h001;
      m1_read = 1'b1; m1_address = 10'h002;
      #1;
      checks++;
      if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL rst_chipselect got %b exp 0", mem_chipselect); end
      checks++;
      if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
         errors++; $display("FAIL rst_waitrequest got m0=%b m1=%b exp m0=0 m1=1", m0_waitrequest, m1_waitrequest);
      end
      checks++;
      if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
         errors++; $display("FAIL rst_rdvalid got m0=%b m1=%b exp 0 0", m0_readdatavalid, m1_readdatavalid);
      end
      checks++;
      if (mem_clken !== 1'b1) begin errors++; $display("FAIL rst_clken got %b exp 1", mem_clken); end
      $display("test_reset: outputs checked while reset_n low");
      @(negedge clk);
      idle_all();
      reset_n = 1'b1;
   endtask

   task automatic test_single_read();
      @(negedge clk);
      idle_all();
      m0_read = 1'b1; m0_address = 10'h005;
      #1;
      checks++;
      if (mem_chipselect !== 1'b1 || mem_address !== 10'h005 || mem_write !== 1'b0) begin
         errors++; $display("FAIL sr_issue got cs=%b addr=%h wr=%b exp cs=1 addr=005 wr=0", mem_chipselect, mem_address, mem_write);
      end
      @(negedge clk);
      idle_all();
      #1;
      checks++;
      if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL sr_return got v=%b d=%h exp v=1 d=deadbeef", m0_readdatavalid, m0_readdata);
      end
      checks++;
      if (m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL sr_m1_quiet got %b exp 0", m1_readdatavalid); end
      checks++;
      if (mem_chipselect !== 1'b0 || mem_address !== 10'h005) begin
         errors++; $display("FAIL sr_idle_hold got cs=%b addr=%h exp cs=0 addr=005", mem_chipselect, mem_address);
      end
      @(negedge clk);
      #1;
      checks++;
      if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL sr_single_pulse got %b exp 0", m0_readdatavalid); end
      $display("test_single_read: m0 read 005");
   endtask

   task automatic test_tie_after_reset();
      do_reset();
      m0_read = 1'b1; m0_address = 10'h020;
      m1_read = 1'b1; m1_address = 10'h021;
      #1;
      checks++;
      if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1 || mem_address !== 10'h020) begin
         errors++; $display("FAIL tie_first got w0=%b w1=%b addr=%h exp w0=0 w1=1 addr=020", m0_waitrequest, m1_waitrequest, mem_address);
      end
      @(negedge clk);
      m0_read = 1'b0;
      #1;
      checks++;
      if (m1_waitrequest !== 1'b0 || mem_address !== 10'h021) begin
         errors++; $display("FAIL tie_second got w1=%b addr=%h exp w1=0 addr=021", m1_waitrequest, mem_address);
      end
      checks++;
      if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 || m0_readdata !== 32'hA0A0_0020) begin
         errors++; $display("FAIL tie_ret0 got v0=%b v1=%b d=%h exp v0=1 v1=0 d=a0a00020", m0_readdatavalid, m1_readdatavalid, m0_readdata);
      end
      @(negedge clk);
      idle_all();
      #1;
      checks++;
      if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0 || m1_readdata !== 32'hB0B0_0021) begin
         errors++; $display("FAIL tie_ret1 got v0=%b v1=%b d=%h exp v0=0 v1=1 d=b0b00021", m0_readdatavalid, m1_readdatavalid, m1_readdata);
      end
      $display("test_tie_after_reset: m0 then m1");
   endtask

   task automatic test_round_robin();
      logic prev_m0, exp_m0;
      prev_m0 = 1'b0;
      do_reset();
      for (int k = 0; k < 24; k++) begin
         if (k > 0) @(negedge clk);
         m0_read = 1'b1; m0_address = 10'h100;
         m1_read = 1'b1; m1_address = 10'h200;
         exp_m0 = ((k / 4) % 2) == 0;
         #1;
         checks++;
         if (mem_address !== (exp_m0 ? 10'h100 : 10'h200) || m0_waitrequest !== !exp_m0 || m1_waitrequest !== exp_m0) begin
            errors++; $display("FAIL rr_grant k=%0d got addr=%h w0=%b w1=%b exp m0_granted=%b", k, mem_address, m0_waitrequest, m1_waitrequest, exp_m0);
         end
         if (k > 0) begin
            checks++;
            if (m0_readdatavalid !== prev_m0 || m1_readdatavalid !== !prev_m0 ||
                mem_readdata !== (prev_m0 ? 32'h0000_0100 : 32'h0000_0200)) begin
               errors++; $display("FAIL rr_return k=%0d got v0=%b v1=%b d=%h exp v0=%b", k, m0_readdatavalid, m1_readdatavalid, mem_readdata, prev_m0);
            end
         end
         prev_m0 = exp_m0;
      end
      @(negedge clk);
      idle_all();
      $display("test_round_robin: 24 contended cycles");
   endtask

   task automatic test_saturate();
      do_reset();
      for (int k = 0; k < 11; k++) begin
         if (k > 0) @(negedge clk);
         m0_read = 1'b1; m0_address = 10'h100;
         m1_read = (k >= 6); m1_address = 10'h200;
         #1;
         if (k >= 6) begin
            checks++;
            if (m0_waitrequest !== (k <= 9) || mem_address !== ((k <= 9) ? 10'h200 : 10'h100)) begin
               errors++; $display("FAIL sat_grant k=%0d got w0=%b addr=%h exp w0=%b", k, m0_waitrequest, mem_address, (k <= 9));
            end
         end
      end
      @(negedge clk);
      idle_all();
      $display("test_saturate: long m0 stream then m1 joins");
   endtask

   task automatic test_write();
      @(negedge clk);
      idle_all();
      m1_write = 1'b1; m1_address = 10'h3FF; m1_byteenable = 4'h3; m1_writedata = 32'h11223344;
      #1;
      checks++;
      if (mem_write !== 1'b1 || mem_chipselect !== 1'b1 || mem_byteenable !== 4'h3 ||
          mem_address !== 10'h3FF || mem_writedata !== 32'h11223344 || m1_waitrequest !== 1'b0) begin
         errors++; $display("FAIL wr_issue got wr=%b cs=%b be=%h addr=%h wd=%h w1=%b exp 1 1 3 3ff 11223344 0",
                            mem_write, mem_chipselect, mem_byteenable, mem_address, mem_writedata, m1_waitrequest);
      end
      @(negedge clk);
      idle_all();
      #1;
      checks++;
      if (mem_write !== 1'b0 || m1_readdatavalid !== 1'b0 || mem_byteenable !== 4'h3) begin
         errors++; $display("FAIL wr_after got wr=%b v1=%b be=%h exp 0 0 3", mem_write, m1_readdatavalid, mem_byteenable);
      end
      m0_read = 1'b1; m0_address = 10'h3FF;
      @(negedge clk);
      idle_all();
      #1;
      checks++;
      if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hAABB3344) begin
         errors++; $display("FAIL wr_readback got v=%b d=%h exp v=1 d=aabb3344", m0_readdatavalid, m0_readdata);
      end
      $display("test_write: m1 partial write 3ff");
   endtask

   task automatic test_read_write_same();
      @(negedge clk);
      idle_all();
      m0_read = 1'b1; m0_write = 1'b1; m0_address = 10'h010; m0_byteenable = 4'hF; m0_writedata = 32'h55667788;
      #1;
      checks++;
      if (mem_write !== 1'b1 || mem_chipselect !== 1'b1) begin
         errors++; $display("FAIL rw_issue got wr=%b cs=%b exp 1 1", mem_write, mem_chipselect);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         idle_all();
         #1;
         checks++;
         if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL rw_no_return k=%0d got v0=%b v1=%b exp 0 0", k, m0_readdatavalid, m1_readdatavalid);
         end
      end
      m0_read = 1'b1; m0_address = 10'h010;
      @(negedge clk);
      idle_all();
      #1;
      checks++;
      if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h55667788) begin
         errors++; $display("FAIL rw_readback got v=%b d=%h exp v=1 d=55667788", m0_readdatavalid, m0_readdata);
      end
      $display("test_read_write_same: read+write at 010");
   endtask

   task automatic test_reset_inflight();
      @(negedge clk);
      idle_all();
      m0_read = 1'b1; m0_address = 10'h005;
      #1;
      checks++;
      if (mem_chipselect !== 1'b1) begin errors++; $display("FAIL rif_issue got cs=%b exp 1", mem_chipselect); end
      @(negedge clk);
      idle_all();
      reset_n = 1'b0;
      #1;
      checks++;
      if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rif_dropped got %b exp 0", m0_readdatavalid); end
      m0_read = 1'b1; m1_read = 1'b1; m0_address = 10'h020; m1_address = 10'h021;
      #1;
      checks++;
      if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL rif_cs_in_reset got %b exp 0", mem_chipselect); end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checks++;
      if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rif_after_release got %b exp 0", m0_readdatavalid); end
      checks++;
      if (m1_waitrequest !== 1'b1 || m0_waitrequest !== 1'b0 || mem_address !== 10'h020 || mem_chipselect !== 1'b1) begin
         errors++; $display("FAIL rif_tie got w0=%b w1=%b addr=%h cs=%b exp 0 1 020 1", m0_waitrequest, m1_waitrequest, mem_address, mem_chipselect);
      end
      @(negedge clk);
      idle_all();
      $display("test_reset_inflight: reset with m0 read outstanding");
   endtask

   initial begin
      reset_n = 1'b0;
      idle_all();
      m0_address = '0; m1_address = '0;
      m0_byteenable = 4'hF; m1_byteenable = 4'hF;
      m0_writedata = '0; m1_writedata = '0;
      test_reset();
      preload(10'h005, 32'hDEADBEEF);
      preload(10'h020, 32'hA0A0_0020);
      preload(10'h021, 32'hB0B0_0021);
      preload(10'h100, 32'h0000_0100);
      preload(10'h200, 32'h0000_0200);
      preload(10'h3FF, 32'hAABBCCDD);
      preload(10'h010, 32'h0000_0000);
      test_single_read();
      test_tie_after_reset();
      test_round_robin();
      test_saturate();
      test_write();
      test_read_write_same();
      test_reset_inflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
